// File: rtl/gol_run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : gol_run_sequencer_if
// Description : Handshake bundle between the run sequencer and the board
//               datapath (setup editor, algorithm engine, board store).
//   setup_en    seq -> dp   setup module may edit the board
//   alg_start   seq -> dp   one-cycle start pulse to the engine
//   board_we    seq -> dp   one-cycle commit of board_next
//   board_clr   seq -> dp   one-cycle board clear
//   alg_done    dp  -> seq  one-cycle pulse: board_next is valid
//   board_cur   dp  -> seq  currently committed board
//   board_next  dp  -> seq  engine result
// Revision    : 1.0  initial release
// ============================================================================
interface gol_run_sequencer_if #(
  parameter int BOARD_BITS = 256
);
  logic                  setup_en;
  logic                  alg_start;
  logic                  board_we;
  logic                  board_clr;
  logic                  alg_done;
  logic [BOARD_BITS-1:0] board_cur;
  logic [BOARD_BITS-1:0] board_next;

  // Sequencer side
  modport master (
    output setup_en, alg_start, board_we, board_clr,
    input  alg_done, board_cur, board_next
  );

  // Datapath side
  modport slave (
    input  setup_en, alg_start, board_we, board_clr,
    output alg_done, board_cur, board_next
  );
endinterface
`default_nettype wire

// File: rtl/gol_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gol_run_sequencer
// Description : Run-control sequencer for the Game of Life board pipeline.
//               Accepts one-cycle user requests, paces generations with a
//               programmable prescaler, hands off to the algorithm engine,
//               commits results, counts generations and auto-halts on
//               still-life / extinct boards.
//   clk, reset          clock, synchronous active-high reset
//   run_req..clear_req  one-cycle user requests (clear > run > step > edit)
//   auto_stop           enable halt on stable / extinct board
//   rate_sel            generation period = 2^(TICK_BASE_LOG2 + rate_sel)
//   bus                 datapath handshake (gol_run_sequencer_if.master)
//   running_o           high in RUN_WAIT, COMPUTE, COMMIT
//   generation_o        committed generation count, saturating
//   halt_stable/halt_extinct/timeout_err  sticky status flags
// Revision    : 1.0  initial release
// ============================================================================
module gol_run_sequencer #(
  parameter int TICK_BASE_LOG2 = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run_req,
  input  logic                       step_req,
  input  logic                       edit_req,
  input  logic                       clear_req,
  input  logic                       auto_stop,
  input  logic [2:0]                 rate_sel,
  gol_run_sequencer_if.master        bus,
  output logic                       running_o,
  output logic [15:0]                generation_o,
  output logic                       halt_stable,
  output logic                       halt_extinct,
  output logic                       timeout_err
);

  // Prescaler wide enough for the slowest period (rate_sel = 7) plus one bit.
  localparam int PS_W = TICK_BASE_LOG2 + 8;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GEN_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    S_SETUP    = 3'd0,
    S_PAUSED   = 3'd1,
    S_RUN_WAIT = 3'd2,
    S_COMPUTE  = 3'd3,
    S_COMMIT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PS_W-1:0]   presc_q, presc_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              pause_pend_q, pause_pend_d;
  logic              step_mode_q, step_mode_d;
  logic [15:0]       generation_q, generation_d;
  logic              halt_stable_q, halt_stable_d;
  logic              halt_extinct_q, halt_extinct_d;
  logic              timeout_err_q, timeout_err_d;
  logic              setup_en_q, setup_en_d;
  logic              running_q, running_d;
  logic              alg_start_q, alg_start_d;
  logic              board_we_q, board_we_d;
  logic              board_clr_q, board_clr_d;

  logic [PS_W-1:0]   period_m1;
  logic              clr_hit;
  logic              stable;
  logic              extinct;
  logic              enter_active;

  // Period minus one is recomputed every cycle so rate_sel changes apply
  // immediately to the running prescaler.
  assign period_m1 = (PS_W'(1) << (TICK_BASE_LOG2 + int'(rate_sel))) - PS_W'(1);
  assign stable    = (bus.board_next == bus.board_cur);
  assign extinct   = (bus.board_next == '0);

  always_comb begin
    state_d        = state_q;
    pause_pend_d   = pause_pend_q;
    step_mode_d    = step_mode_q;
    generation_d   = generation_q;
    halt_stable_d  = halt_stable_q;
    halt_extinct_d = halt_extinct_q;
    timeout_err_d  = timeout_err_q;
    clr_hit        = 1'b0;

    case (state_q)
      S_SETUP: begin
        if (clear_req) begin
          clr_hit = 1'b1;
        end else if (run_req) begin
          state_d = S_RUN_WAIT;
        end else if (step_req) begin
          state_d     = S_COMPUTE;
          step_mode_d = 1'b1;
        end
      end
      S_PAUSED: begin
        if (clear_req) begin
          clr_hit = 1'b1;
          state_d = S_SETUP;
        end else if (run_req) begin
          state_d = S_RUN_WAIT;
        end else if (step_req) begin
          state_d     = S_COMPUTE;
          step_mode_d = 1'b1;
        end else if (edit_req) begin
          state_d = S_SETUP;
        end
      end
      S_RUN_WAIT: begin
        if (run_req) begin
          state_d = S_PAUSED;
        end else if (presc_q >= period_m1) begin
          state_d     = S_COMPUTE;
          step_mode_d = 1'b0;
        end
      end
      S_COMPUTE: begin
        if (run_req) begin
          pause_pend_d = 1'b1;
        end
        // wd_q == 0 marks the alg_start cycle; a done pulse there is stale.
        if (bus.alg_done && (wd_q != '0)) begin
          state_d = S_COMMIT;
        end else if (wd_q == WD_LAST) begin
          state_d       = S_PAUSED;
          timeout_err_d = 1'b1;
          pause_pend_d  = 1'b0;
        end
      end
      S_COMMIT: begin
        pause_pend_d = 1'b0;
        if (generation_q != GEN_MAX) begin
          generation_d = generation_q + 16'd1;
        end
        if (auto_stop && extinct) begin
          halt_extinct_d = 1'b1;
          state_d        = S_PAUSED;
        end else if (auto_stop && stable) begin
          halt_stable_d = 1'b1;
          state_d       = S_PAUSED;
        end else if (pause_pend_q || step_mode_q) begin
          state_d = S_PAUSED;
        end else begin
          state_d = S_RUN_WAIT;
        end
      end
      default: begin
        state_d = S_SETUP;
      end
    endcase

    enter_active = ((state_d == S_RUN_WAIT) && (state_q != S_RUN_WAIT)) ||
                   ((state_d == S_COMPUTE)  && (state_q != S_COMPUTE));

    // Flag sets and clears never coincide: sets only occur on the way to
    // PAUSED, clears only on the way to RUN_WAIT/COMPUTE or on clear.
    if (enter_active || clr_hit) begin
      halt_stable_d  = 1'b0;
      halt_extinct_d = 1'b0;
      timeout_err_d  = 1'b0;
    end
    if (clr_hit) begin
      generation_d = 16'd0;
    end

    // Counters restart at zero on every entry to their state.
    presc_d = ((state_d == S_RUN_WAIT) && (state_q == S_RUN_WAIT)) ?
              presc_q + PS_W'(1) : '0;
    wd_d    = ((state_d == S_COMPUTE) && (state_q == S_COMPUTE)) ?
              wd_q + WD_W'(1) : '0;

    setup_en_d  = (state_d == S_SETUP);
    running_d   = (state_d == S_RUN_WAIT) || (state_d == S_COMPUTE) ||
                  (state_d == S_COMMIT);
    alg_start_d = (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
    board_we_d  = (state_d == S_COMMIT);
    board_clr_d = clr_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_SETUP;
      presc_q        <= '0;
      wd_q           <= '0;
      pause_pend_q   <= 1'b0;
      step_mode_q    <= 1'b0;
      generation_q   <= 16'd0;
      halt_stable_q  <= 1'b0;
      halt_extinct_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      setup_en_q     <= 1'b1;
      running_q      <= 1'b0;
      alg_start_q    <= 1'b0;
      board_we_q     <= 1'b0;
      board_clr_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      wd_q           <= wd_d;
      pause_pend_q   <= pause_pend_d;
      step_mode_q    <= step_mode_d;
      generation_q   <= generation_d;
      halt_stable_q  <= halt_stable_d;
      halt_extinct_q <= halt_extinct_d;
      timeout_err_q  <= timeout_err_d;
      setup_en_q     <= setup_en_d;
      running_q      <= running_d;
      alg_start_q    <= alg_start_d;
      board_we_q     <= board_we_d;
      board_clr_q    <= board_clr_d;
    end
  end

  assign bus.setup_en  = setup_en_q;
  assign bus.alg_start = alg_start_q;
  assign bus.board_we  = board_we_q;
  assign bus.board_clr = board_clr_q;
  assign running_o     = running_q;
  assign generation_o  = generation_q;
  assign halt_stable   = halt_stable_q;
  assign halt_extinct  = halt_extinct_q;
  assign timeout_err   = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gol_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gol_run_sequencer
// Description : Directed self-checking bench for gol_run_sequencer with
//               TICK_BASE_LOG2=4 (16-cycle base period) and TIMEOUT_CYCLES=8.
//               A small engine responder returns alg_done 5 cycles after
//               alg_start unless disabled.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gol_run_sequencer;
  localparam int BB = 256;
  localparam logic [BB-1:0] BLINK_H = BB'(7) << (16 * 5 + 4);
  localparam logic [BB-1:0] BLINK_V = (BB'(1) << (16 * 4 + 5)) |
                                      (BB'(1) << (16 * 5 + 5)) |
                                      (BB'(1) << (16 * 6 + 5));
  localparam logic [BB-1:0] BLOCK   = (BB'(3) << (16 * 8 + 8)) |
                                      (BB'(3) << (16 * 9 + 8));

  logic        clk = 1'b0;
  logic        reset;
  logic        run_req, step_req, edit_req, clear_req, auto_stop;
  logic [2:0]  rate_sel;
  logic        running_o, halt_stable, halt_extinct, timeout_err;
  logic [15:0] generation_o;

  logic        eng_en;
  logic        spur_done;
  int          eng_cnt = 0;
  int          n_start = 0;
  int          n_we = 0;
  int          snap_start, snap_we;

  int          n_cmp = 0;
  int          n_bad = 0;

  gol_run_sequencer_if #(.BOARD_BITS(BB)) bus ();

  gol_run_sequencer #(
    .TICK_BASE_LOG2 (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run_req      (run_req),
    .step_req     (step_req),
    .edit_req     (edit_req),
    .clear_req    (clear_req),
    .auto_stop    (auto_stop),
    .rate_sel     (rate_sel),
    .bus          (bus),
    .running_o    (running_o),
    .generation_o (generation_o),
    .halt_stable  (halt_stable),
    .halt_extinct (halt_extinct),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Engine responder: alg_done exactly 5 cycles after an alg_start.
  always @(posedge clk) begin
    if (reset) eng_cnt <= 0;
    else if (bus.alg_start && eng_en) eng_cnt <= 5;
    else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
  end
  assign bus.alg_done = (eng_cnt == 1) || spur_done;

  // Pulse counters for "exactly one" style checks.
  always @(posedge clk) begin
    if (bus.alg_start) n_start <= n_start + 1;
    if (bus.board_we)  n_we    <= n_we + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_run();
    run_req = 1'b1; tick(1); run_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run_req = 1'b0; step_req = 1'b0; edit_req = 1'b0;
    clear_req = 1'b0; auto_stop = 1'b0; rate_sel = 3'd0;
    eng_en = 1'b1; spur_done = 1'b0;
    bus.board_cur = BLINK_H; bus.board_next = BLINK_V;
    tick(2);
    reset = 1'b0;

    // Reset values
    check_eq("rst_setup_en", 32'(bus.setup_en), 32'd1);
    check_eq("rst_running", 32'(running_o), 32'd0);
    check_eq("rst_pulses", 32'({bus.alg_start, bus.board_we, bus.board_clr}), 32'd0);
    check_eq("rst_gen", 32'(generation_o), 32'd0);
    check_eq("rst_flags", 32'({halt_stable, halt_extinct, timeout_err}), 32'd0);

    // Continuous run, rate_sel=0 (period 16), engine latency 5
    pulse_run();                                               // N+1
    check_eq("run_enter_running", 32'(running_o), 32'd1);
    check_eq("run_enter_setup_en", 32'(bus.setup_en), 32'd0);
    tick(15);                                                  // N+16
    check_eq("run_start_early", 32'(bus.alg_start), 32'd0);
    tick(1);                                                   // N+17
    check_eq("run_start", 32'(bus.alg_start), 32'd1);
    tick(5);                                                   // N+22 (alg_done)
    check_eq("run_we_early", 32'(bus.board_we), 32'd0);
    tick(1);                                                   // N+23
    check_eq("run_we", 32'(bus.board_we), 32'd1);
    check_eq("run_gen_before", 32'(generation_o), 32'd0);
    tick(1);                                                   // N+24
    check_eq("run_gen1", 32'(generation_o), 32'd1);
    check_eq("run_we_off", 32'(bus.board_we), 32'd0);
    tick(16);                                                  // N+40
    check_eq("run_start2", 32'(bus.alg_start), 32'd1);
    tick(7);                                                   // N+47
    check_eq("run_gen2", 32'(generation_o), 32'd2);
    pulse_run();                                               // PAUSED
    check_eq("pause_running", 32'(running_o), 32'd0);
    check_eq("pause_setup_en", 32'(bus.setup_en), 32'd0);

    // Single step from PAUSED
    snap_start = n_start; snap_we = n_we;
    step_req = 1'b1; tick(1); step_req = 1'b0;                 // P+1
    check_eq("step_start", 32'(bus.alg_start), 32'd1);
    tick(6);                                                   // P+7
    check_eq("step_we", 32'(bus.board_we), 32'd1);
    tick(1);                                                   // P+8
    check_eq("step_gen", 32'(generation_o), 32'd3);
    check_eq("step_running", 32'(running_o), 32'd0);
    tick(20);
    check_eq("step_n_start", 32'(n_start - snap_start), 32'd1);
    check_eq("step_n_we", 32'(n_we - snap_we), 32'd1);
    check_eq("step_still_paused", 32'(running_o), 32'd0);

    // Auto-stop: blinker generation continues, then block halts
    auto_stop = 1'b1;
    pulse_run();                                               // R+1
    tick(23);                                                  // R+24
    check_eq("blink_no_halt", 32'(halt_stable), 32'd0);
    check_eq("blink_running", 32'(running_o), 32'd1);
    check_eq("blink_gen", 32'(generation_o), 32'd4);
    bus.board_cur = BLOCK; bus.board_next = BLOCK;
    tick(23);                                                  // R+47
    check_eq("block_halt_stable", 32'(halt_stable), 32'd1);
    check_eq("block_no_extinct", 32'(halt_extinct), 32'd0);
    check_eq("block_paused", 32'(running_o), 32'd0);
    check_eq("block_gen", 32'(generation_o), 32'd5);

    // All-zero fixed point: extinct wins over stable
    bus.board_cur = '0; bus.board_next = '0;
    pulse_run();                                               // E+1
    check_eq("ext_flag_cleared", 32'(halt_stable), 32'd0);
    tick(23);                                                  // E+24
    check_eq("ext_halt_extinct", 32'(halt_extinct), 32'd1);
    check_eq("ext_no_stable", 32'(halt_stable), 32'd0);
    check_eq("ext_paused", 32'(running_o), 32'd0);
    check_eq("ext_gen", 32'(generation_o), 32'd6);
    auto_stop = 1'b0;

    // Watchdog timeout: engine silent
    eng_en = 1'b0; bus.board_cur = BLINK_H; bus.board_next = BLINK_V;
    snap_we = n_we;
    step_req = 1'b1; tick(1); step_req = 1'b0;                 // T+1
    check_eq("to_start", 32'(bus.alg_start), 32'd1);
    check_eq("to_ext_cleared", 32'(halt_extinct), 32'd0);
    tick(7);                                                   // T+8
    check_eq("to_not_yet", 32'(timeout_err), 32'd0);
    check_eq("to_still_running", 32'(running_o), 32'd1);
    tick(1);                                                   // T+9
    check_eq("to_err", 32'(timeout_err), 32'd1);
    check_eq("to_paused", 32'(running_o), 32'd0);
    check_eq("to_no_we", 32'(n_we - snap_we), 32'd0);
    check_eq("to_gen", 32'(generation_o), 32'd6);
    eng_en = 1'b1;
    pulse_run();
    check_eq("to_err_cleared", 32'(timeout_err), 32'd0);
    pulse_run();
    check_eq("to_repause", 32'(running_o), 32'd0);

    // clear + run together in PAUSED: clear wins, run dropped
    clear_req = 1'b1; run_req = 1'b1; tick(1); clear_req = 1'b0; run_req = 1'b0;
    check_eq("clr_pulse", 32'(bus.board_clr), 32'd1);
    check_eq("clr_gen", 32'(generation_o), 32'd0);
    check_eq("clr_setup", 32'(bus.setup_en), 32'd1);
    check_eq("clr_not_running", 32'(running_o), 32'd0);
    tick(1);
    check_eq("clr_pulse_end", 32'(bus.board_clr), 32'd0);
    check_eq("clr_stay_setup", 32'({bus.setup_en, running_o}), 32'b10);

    // run_req during COMPUTE with rate_sel=1 (period 32)
    rate_sel = 3'd1;
    pulse_run();                                               // S+1
    tick(31);                                                  // S+32
    check_eq("r1_start_early", 32'(bus.alg_start), 32'd0);
    tick(1);                                                   // S+33
    check_eq("r1_start", 32'(bus.alg_start), 32'd1);
    tick(1);                                                   // S+34
    pulse_run();                                               // S+35
    tick(4);                                                   // S+39
    check_eq("pp_we", 32'(bus.board_we), 32'd1);
    tick(1);                                                   // S+40
    check_eq("pp_gen", 32'(generation_o), 32'd1);
    check_eq("pp_paused", 32'({bus.setup_en, running_o}), 32'b00);

    // edit_req from PAUSED returns to SETUP
    edit_req = 1'b1; tick(1); edit_req = 1'b0;
    check_eq("edit_setup", 32'(bus.setup_en), 32'd1);

    // alg_done outside COMPUTE is ignored
    spur_done = 1'b1; tick(1); spur_done = 1'b0;
    check_eq("spur_no_we", 32'(bus.board_we), 32'd0);
    tick(1);
    check_eq("spur_gen", 32'(generation_o), 32'd1);

    // Saturation from 16'hFFFE
    rate_sel = 3'd0;
    force dut.generation_q = 16'hFFFE;
    tick(1);
    release dut.generation_q;
    check_eq("sat_preload", 32'(generation_o), 32'h0000FFFE);
    snap_we = n_we;
    pulse_run();                                               // G+1
    tick(23);                                                  // G+24
    check_eq("sat_gen1", 32'(generation_o), 32'h0000FFFF);
    tick(46);                                                  // G+70
    check_eq("sat_gen3", 32'(generation_o), 32'h0000FFFF);
    check_eq("sat_n_we", 32'(n_we - snap_we), 32'd3);

    // Reset in the middle of COMPUTE
    tick(17);                                                  // G+87
    check_eq("rc_in_compute", 32'(running_o), 32'd1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check_eq("rc_gen", 32'(generation_o), 32'd0);
    check_eq("rc_setup", 32'(bus.setup_en), 32'd1);
    check_eq("rc_pulses", 32'({bus.alg_start, bus.board_we}), 32'd0);
    check_eq("rc_running", 32'(running_o), 32'd0);
    snap_start = n_start; snap_we = n_we;
    tick(10);
    check_eq("rc_no_we", 32'(n_we - snap_we), 32'd0);
    check_eq("rc_no_start", 32'(n_start - snap_start), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gol_run_sequencer.md
# gol_run_sequencer

Run-control sequencer for the Game of Life board pipeline. Replaces free-running generation stepping with a handshaked schedule:
- accepts debounced one-cycle user requests (run/pause, single step, edit, clear);
- paces generations with a programmable prescaler;
- starts the algorithm engine and waits for its done handshake;
- commits the next board and counts generations;
- auto-halts on still-life or extinct boards.

Sits between the button/switch front end and the setup/algorithm/transfer datapath.

## Interface
- BOARD_BITS, 256: cells per board (16x16).
- TICK_BASE_LOG2, 20: log2 of the fastest generation period in clk cycles.
- TIMEOUT_CYCLES, 4096: max cycles to wait for alg_done before aborting.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- run_req  in  1  one-cycle pulse: start/pause toggle.
- step_req  in  1  one-cycle pulse: compute exactly one generation.
- edit_req  in  1  one-cycle pulse: return to setup (edit) mode.
- clear_req  in  1  one-cycle pulse: clear board and generation count.
- auto_stop  in  1  level: enable halt on stable/extinct board.
- rate_sel  in  3  period = 2^(TICK_BASE_LOG2 + rate_sel) cycles.
- alg_done  in  1  one-cycle pulse from algorithm engine: board_next valid.
- board_cur  in  BOARD_BITS  currently committed board.
- board_next  in  BOARD_BITS  engine result.
- setup_en  out  1  setup module may edit board.
- alg_start  out  1  one-cycle start pulse to engine.
- board_we  out  1  one-cycle commit of board_next.
- board_clr  out  1  one-cycle board clear.
- running_o  out  1  high in RUN_WAIT, COMPUTE, COMMIT.
- generation_o  out  16  committed generation count, saturating.
- halt_stable  out  1  sticky: halted because board_next == board_cur.
- halt_extinct  out  1  sticky: halted because board_next == 0.
- timeout_err  out  1  sticky: engine failed to respond.

## Operation
- States: SETUP, PAUSED, RUN_WAIT, COMPUTE, COMMIT. Reset enters SETUP.
- Request priority in a cycle: clear > run > step > edit. Lower-priority requests in the same cycle are dropped.
- SETUP (setup_en=1):
  - clear_req: board_clr, generation_o=0, stay in SETUP.
  - run_req: go to RUN_WAIT.
  - step_req: go to COMPUTE.
  - edit_req: ignored.
- PAUSED:
  - clear_req: board_clr, generation_o=0, go to SETUP.
  - run_req: go to RUN_WAIT.
  - step_req: go to COMPUTE.
  - edit_req: go to SETUP.
- RUN_WAIT:
  - Prescaler counter clears on entry and increments each cycle.
  - When count >= period-1: go to COMPUTE. A rate_sel change takes effect immediately.
  - run_req: go to PAUSED.
  - step_req, edit_req, clear_req: ignored.
- COMPUTE:
  - alg_start is asserted in the first cycle only.
  - alg_done is honored from the second cycle on; it then goes to COMMIT.
  - Watchdog counts cycles in COMPUTE. At TIMEOUT_CYCLES without alg_done: set timeout_err, go to PAUSED, no commit.
  - run_req here sets pause_pending. step_req, edit_req, clear_req: ignored.
- COMMIT (one cycle):
  - board_we=1.
  - generation_o increments, holding at 16'hFFFF.
  - stable = (board_next == board_cur); extinct = (board_next == 0), both sampled this cycle.
  - Next state is the first true condition:
    - auto_stop && extinct: set halt_extinct, go to PAUSED.
    - auto_stop && stable: set halt_stable, go to PAUSED.
    - pause_pending, or COMPUTE was entered via step: go to PAUSED.
    - Otherwise: go to RUN_WAIT.
  - pause_pending clears on leaving COMMIT.
- Extinct takes precedence over stable; an all-zero fixed point sets only halt_extinct.
- Sticky flags (halt_stable, halt_extinct, timeout_err) clear on any transition into RUN_WAIT or COMPUTE, on clear_req, and on reset.

## Timing
- Reset values:
  - setup_en=1.
  - alg_start, board_we, board_clr, running_o = 0.
  - generation_o=0.
  - All flags 0.
  - Prescaler, watchdog and pause_pending = 0.
- All outputs are registered; each reflects the state/decision of the prior edge.
- Request accepted in cycle N: state change is visible at N+1.
- clear_req accepted in cycle N: board_clr is high in N+1 and generation_o reads 0 from N+1.
- run_req in SETUP at N: RUN_WAIT at N+1, COMPUTE (alg_start high) at N+1+period.
- alg_done at cycle M: COMMIT (board_we high) at M+1. Generation_o increments and is visible at M+2.
- Minimum generation turnaround: period + 3 cycles in continuous run.
- reset mid-COMPUTE or mid-COMMIT:
  - Any in-flight result is abandoned.
  - No board_we or alg_start in the cycle after reset.
- alg_done outside COMPUTE is ignored.

## Test plan
- Reset, then run_req with rate_sel=0, TICK_BASE_LOG2=4. Engine returns alg_done 5 cycles after alg_start. Required:
  - alg_start 16 cycles after RUN_WAIT entry;
  - board_we 1 cycle after alg_done;
  - generation_o 0→1→2 on successive periods.
- From PAUSED, step_req with board_next≠board_cur: exactly one alg_start and one board_we, generation_o +1, return to PAUSED, running_o low afterwards.
- auto_stop=1, blinker then block pattern (board_next==board_cur): halt_stable=1 after the first stable COMMIT, state PAUSED. Repeat with board_next=0: only halt_extinct=1.
- Engine never asserts alg_done, TIMEOUT_CYCLES=8: timeout_err=1 after 8 COMPUTE cycles, no board_we, state PAUSED. Next run_req clears timeout_err.
- clear_req and run_req in the same cycle in PAUSED: board_clr pulse, generation_o=0, state SETUP, run dropped. run_req during COMPUTE: current generation commits, then PAUSED.
- Preload generation_o to 16'hFFFE and run 3 generations: holds at 16'hFFFF. Assert reset during COMPUTE: generation_o=0, SETUP, no board_we.
